// File: rtl/s2p_pkg.sv
// s2p_pkg: shared constants and Gray-to-binary helper for the QAM
// serial-to-parallel symbol packer.
package s2p_pkg;

    localparam int unsigned S2P_MAX_BITS = 8;
    localparam int unsigned S2P_CNT_W    = 3;
    localparam int unsigned S2P_MAX_HW   = S2P_MAX_BITS / 2;

    // Gray to binary over the widest half; narrower halves are zero-extended
    // at the MSB end, which leaves the lower result bits unchanged.
    function automatic logic [S2P_MAX_HW-1:0] gray2bin(input logic [S2P_MAX_HW-1:0] g);
        logic [S2P_MAX_HW-1:0] b;
        b[S2P_MAX_HW-1] = g[S2P_MAX_HW-1];
        for (int unsigned j = 1; j < S2P_MAX_HW; j++) begin
            b[S2P_MAX_HW-1-j] = b[S2P_MAX_HW-j] ^ g[S2P_MAX_HW-1-j];
        end
        return b;
    endfunction

endpackage

// File: rtl/s2p_gray2bin.sv
// s2p_gray2bin: combinational Gray-to-binary converter for one symbol half.
module s2p_gray2bin
    import s2p_pkg::*;
#(
    parameter int unsigned HW = 2
) (
    input  logic [HW-1:0] gray,
    output logic [HW-1:0] bin
);

    logic [S2P_MAX_HW-1:0] gray_ext;
    logic [S2P_MAX_HW-1:0] bin_ext;

    // Widen to the package function width, convert, and narrow back.
    always_comb begin
        gray_ext         = '0;
        gray_ext[HW-1:0] = gray;
        bin_ext          = gray2bin(gray_ext);
        bin              = bin_ext[HW-1:0];
    end

endmodule

// File: rtl/s2p_symbol_packer.sv
// s2p_symbol_packer: collects BITS_PER_SYM serial bits, splits the word into
// I (upper half) and Q (lower half) and holds it in a one-deep valid/ready
// output register. Define S2P_GRAY_DECODE_EN to Gray-decode each half
// before it is loaded.
module s2p_symbol_packer
    import s2p_pkg::*;
#(
    parameter int unsigned BITS_PER_SYM = 4
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      bit_in,
    input  logic                      bit_valid,
    input  logic                      frame_sync,
    output logic [BITS_PER_SYM/2-1:0] sym_i,
    output logic [BITS_PER_SYM/2-1:0] sym_q,
    output logic                      sym_valid,
    input  logic                      sym_ready,
    output logic [S2P_CNT_W-1:0]      bit_cnt,
    output logic                      overrun,
    input  logic                      overrun_clr
);

    localparam int unsigned HW = BITS_PER_SYM / 2;
    // The partial register never needs the final bit, so it is one bit short.
    localparam int unsigned PW = BITS_PER_SYM - 1;
    localparam logic [S2P_CNT_W-1:0] LAST_CNT = S2P_CNT_W'(BITS_PER_SYM - 1);

    logic [PW-1:0]           part_q;
    logic [PW-1:0]           part_base;
    logic [PW-1:0]           part_d;
    logic [S2P_CNT_W-1:0]    cnt_base;
    logic [S2P_CNT_W-1:0]    cnt_d;
    logic [BITS_PER_SYM-1:0] word;
    logic [HW-1:0]           half_i;
    logic [HW-1:0]           half_q;
    logic                    complete;
    logic                    load;
    logic                    drop;

    // Frame alignment, bit shifting and symbol completion / load decision.
    always_comb begin
        cnt_base  = frame_sync ? '0 : bit_cnt;
        part_base = frame_sync ? '0 : part_q;
        word      = {part_base, bit_in};
        complete  = bit_valid && (cnt_base == LAST_CNT);
        cnt_d     = cnt_base;
        part_d    = part_base;
        if (bit_valid) begin
            if (complete) begin
                cnt_d  = '0;
                part_d = '0;
            end else begin
                cnt_d  = cnt_base + 1'b1;
                part_d = word[PW-1:0];
            end
        end
        load = complete && (!sym_valid || sym_ready);
        drop = complete && !load;
    end

`ifdef S2P_GRAY_DECODE_EN
    s2p_gray2bin #(.HW(HW)) u_gray_i (
        .gray (word[BITS_PER_SYM-1:HW]),
        .bin  (half_i)
    );

    s2p_gray2bin #(.HW(HW)) u_gray_q (
        .gray (word[HW-1:0]),
        .bin  (half_q)
    );
`else
    assign half_i = word[BITS_PER_SYM-1:HW];
    assign half_q = word[HW-1:0];
`endif

    // Bit counter and partial-symbol register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt <= '0;
            part_q  <= '0;
        end else begin
            bit_cnt <= cnt_d;
            part_q  <= part_d;
        end
    end

    // Output register with valid/ready handshake and sticky overrun flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sym_i     <= '0;
            sym_q     <= '0;
            sym_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (load) begin
                sym_i     <= half_i;
                sym_q     <= half_q;
                sym_valid <= 1'b1;
            end else if (sym_valid && sym_ready) begin
                sym_valid <= 1'b0;
            end
            if (drop) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_s2p_symbol_packer.sv
// tb_s2p_symbol_packer: scoreboard bench for s2p_symbol_packer with a
// 4-bit-symbol instance and a 2-bit-symbol instance.
module tb_s2p_symbol_packer;

    logic       clock = 1'b0;
    logic       reset_n;

    logic       a_bit_in, a_bit_valid, a_frame_sync, a_sym_ready, a_overrun_clr;
    logic [1:0] a_sym_i, a_sym_q;
    logic       a_sym_valid, a_overrun;
    logic [2:0] a_bit_cnt;

    logic       b_bit_in, b_bit_valid, b_frame_sync, b_sym_ready, b_overrun_clr;
    logic [0:0] b_sym_i, b_sym_q;
    logic       b_sym_valid, b_overrun;
    logic [2:0] b_bit_cnt;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] sb4[$];
    logic [7:0] sb2[$];

    always #5 clock = ~clock;

    s2p_symbol_packer #(.BITS_PER_SYM(4)) dut4 (
        .clock       (clock),
        .reset_n     (reset_n),
        .bit_in      (a_bit_in),
        .bit_valid   (a_bit_valid),
        .frame_sync  (a_frame_sync),
        .sym_i       (a_sym_i),
        .sym_q       (a_sym_q),
        .sym_valid   (a_sym_valid),
        .sym_ready   (a_sym_ready),
        .bit_cnt     (a_bit_cnt),
        .overrun     (a_overrun),
        .overrun_clr (a_overrun_clr)
    );

    s2p_symbol_packer #(.BITS_PER_SYM(2)) dut2 (
        .clock       (clock),
        .reset_n     (reset_n),
        .bit_in      (b_bit_in),
        .bit_valid   (b_bit_valid),
        .frame_sync  (b_frame_sync),
        .sym_i       (b_sym_i),
        .sym_q       (b_sym_q),
        .sym_valid   (b_sym_valid),
        .sym_ready   (b_sym_ready),
        .bit_cnt     (b_bit_cnt),
        .overrun     (b_overrun),
        .overrun_clr (b_overrun_clr)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected {I,Q} for a 4-bit symbol whose first-received bit is w[3].
    function automatic logic [3:0] exp4(input logic [3:0] w);
        logic [1:0] i;
        logic [1:0] q;
        i = w[3:2];
        q = w[1:0];
`ifdef S2P_GRAY_DECODE_EN
        i = {i[1], i[1] ^ i[0]};
        q = {q[1], q[1] ^ q[0]};
`endif
        return {i, q};
    endfunction

    // One clock cycle on the 4-bit instance; a handshake pops the scoreboard.
    task automatic cyc4(input logic bv, input logic b, input logic fs, input logic rdy, input logic clr);
        logic [7:0] e;
        a_bit_valid   = bv;
        a_bit_in      = b;
        a_frame_sync  = fs;
        a_sym_ready   = rdy;
        a_overrun_clr = clr;
        if (a_sym_valid && rdy) begin
            if (sb4.size() == 0) begin
                check_val("sb4_unexpected_sym", {28'd0, a_sym_i, a_sym_q}, 32'hFFFF_FFFF);
            end else begin
                e = sb4.pop_front();
                check_val("sym4_iq", {28'd0, a_sym_i, a_sym_q}, {24'd0, e});
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic cyc2(input logic bv, input logic b, input logic rdy);
        logic [7:0] e;
        b_bit_valid = bv;
        b_bit_in    = b;
        b_sym_ready = rdy;
        if (b_sym_valid && rdy) begin
            if (sb2.size() == 0) begin
                check_val("sb2_unexpected_sym", {30'd0, b_sym_i, b_sym_q}, 32'hFFFF_FFFF);
            end else begin
                e = sb2.pop_front();
                check_val("sym2_iq", {30'd0, b_sym_i, b_sym_q}, {24'd0, e});
            end
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n = 1'b1;
        {a_bit_in, a_bit_valid, a_frame_sync, a_sym_ready, a_overrun_clr} = '0;
        {b_bit_in, b_bit_valid, b_frame_sync, b_sym_ready, b_overrun_clr} = '0;
        #1 reset_n = 1'b0;
        #16;
        check_val("rst_bit_cnt", a_bit_cnt, 0);
        check_val("rst_sym_i", a_sym_i, 0);
        check_val("rst_sym_q", a_sym_q, 0);
        check_val("rst_sym_valid", a_sym_valid, 0);
        check_val("rst_overrun", a_overrun, 0);
        #5 reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Basic symbol 1011 with ready high.
        cyc4(1, 1, 0, 1, 0);
        cyc4(1, 0, 0, 1, 0);
        cyc4(1, 1, 0, 1, 0);
        sb4.push_back(exp4(4'b1011));
        cyc4(1, 1, 0, 1, 0);
        check_val("t1_valid", a_sym_valid, 1);
        check_val("t1_cnt_wrap", a_bit_cnt, 0);
        cyc4(0, 0, 0, 1, 0);
        check_val("t1_valid_one_cycle", a_sym_valid, 0);

        // Backpressure: slack of 3 bits, then overrun on the 4th.
        cyc4(1, 1, 0, 0, 0);
        cyc4(1, 0, 0, 0, 0);
        cyc4(1, 1, 0, 0, 0);
        sb4.push_back(exp4(4'b1011));
        cyc4(1, 1, 0, 0, 0);
        check_val("t2_valid", a_sym_valid, 1);
        cyc4(1, 0, 0, 0, 0);
        cyc4(1, 0, 0, 0, 0);
        cyc4(1, 0, 0, 0, 0);
        check_val("t2_slack_no_ovr", a_overrun, 0);
        cyc4(1, 0, 0, 0, 0);
        check_val("t2_overrun", a_overrun, 1);
        check_val("t2_still_valid", a_sym_valid, 1);
        check_val("t2_hold_iq", {a_sym_i, a_sym_q}, exp4(4'b1011));
        cyc4(0, 0, 0, 0, 1);
        check_val("t2_ovr_clr", a_overrun, 0);

        // Drain and load in the same cycle.
        cyc4(1, 0, 0, 0, 0);
        cyc4(1, 1, 0, 0, 0);
        cyc4(1, 1, 0, 0, 0);
        sb4.push_back(exp4(4'b0111));
        cyc4(1, 1, 0, 1, 0);
        check_val("t2_swap_valid", a_sym_valid, 1);
        check_val("t2_swap_no_ovr", a_overrun, 0);
        cyc4(0, 0, 0, 1, 0);
        check_val("t2_drained", a_sym_valid, 0);

        // Overrun set wins over a coincident clear.
        sb4.push_back(exp4(4'b1100));
        cyc4(1, 1, 0, 0, 0);
        cyc4(1, 1, 0, 0, 0);
        cyc4(1, 0, 0, 0, 0);
        cyc4(1, 0, 0, 0, 0);
        cyc4(1, 0, 0, 0, 0);
        cyc4(1, 0, 0, 0, 0);
        cyc4(1, 0, 0, 0, 0);
        cyc4(1, 0, 0, 0, 1);
        check_val("t3_set_wins", a_overrun, 1);
        cyc4(0, 0, 0, 0, 1);
        check_val("t3_clr", a_overrun, 0);
        cyc4(0, 0, 0, 1, 0);

        // frame_sync coincident with bit_valid restarts the symbol.
        cyc4(1, 1, 0, 1, 0);
        check_val("t4_cnt_a", a_bit_cnt, 1);
        cyc4(1, 1, 0, 1, 0);
        check_val("t4_cnt_b", a_bit_cnt, 2);
        cyc4(1, 0, 1, 1, 0);
        check_val("t4_cnt_c", a_bit_cnt, 1);
        cyc4(1, 1, 0, 1, 0);
        check_val("t4_cnt_d", a_bit_cnt, 2);
        cyc4(1, 0, 0, 1, 0);
        check_val("t4_cnt_e", a_bit_cnt, 3);
        sb4.push_back(exp4(4'b0101));
        cyc4(1, 1, 0, 1, 0);
        check_val("t4_cnt_f", a_bit_cnt, 0);
        check_val("t4_valid", a_sym_valid, 1);
        cyc4(0, 0, 0, 1, 0);

        // frame_sync alone realigns the boundary.
        cyc4(1, 1, 0, 1, 0);
        cyc4(1, 1, 0, 1, 0);
        cyc4(0, 0, 1, 1, 0);
        check_val("t5_fs_cnt", a_bit_cnt, 0);
        cyc4(1, 0, 0, 1, 0);
        cyc4(1, 0, 0, 1, 0);
        cyc4(1, 1, 0, 1, 0);
        sb4.push_back(exp4(4'b0011));
        cyc4(1, 1, 0, 1, 0);
        cyc4(0, 0, 0, 1, 0);

        // Asynchronous reset mid-symbol with a held symbol.
        cyc4(1, 1, 0, 0, 0);
        cyc4(1, 0, 0, 0, 0);
        cyc4(1, 0, 0, 0, 0);
        cyc4(1, 1, 0, 0, 0);
        cyc4(1, 1, 0, 0, 0);
        cyc4(1, 1, 0, 0, 0);
        cyc4(0, 0, 0, 0, 0);
        check_val("t6_pre_valid", a_sym_valid, 1);
        check_val("t6_pre_cnt", a_bit_cnt, 2);
        #2 reset_n = 1'b0;
        #1;
        check_val("t6_rst_valid", a_sym_valid, 0);
        check_val("t6_rst_cnt", a_bit_cnt, 0);
        check_val("t6_rst_iq", {a_sym_i, a_sym_q}, 0);
        check_val("t6_rst_ovr", a_overrun, 0);
        sb4.delete();
        @(posedge clock);
        #2 reset_n = 1'b1;
        @(posedge clock);
        #1;
        cyc4(1, 0, 0, 1, 0);
        cyc4(1, 1, 0, 1, 0);
        cyc4(1, 1, 0, 1, 0);
        sb4.push_back(exp4(4'b0110));
        cyc4(1, 0, 0, 1, 0);
        check_val("t6_post_valid", a_sym_valid, 1);
        cyc4(0, 0, 0, 1, 0);

        // 2-bit symbols back to back.
        cyc2(1, 1, 1);
        sb2.push_back(8'b10);
        cyc2(1, 0, 1);
        check_val("t7_valid_a", b_sym_valid, 1);
        cyc2(1, 0, 1);
        sb2.push_back(8'b01);
        cyc2(1, 1, 1);
        check_val("t7_valid_b", b_sym_valid, 1);
        cyc2(0, 0, 1);
        check_val("t7_drained", b_sym_valid, 0);
        check_val("t7_no_ovr", b_overrun, 0);

        check_val("sb4_empty", sb4.size(), 0);
        check_val("sb2_empty", sb2.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
